pc_stack: RTL and testbench



---
 rtl/pc_stack.sv | 65 ++++++
 tb/tb_pc_stack.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// pc_stack: program counter with relative branch, call/return stack, stall and reset vector.
// Define PC_TRAP_EN to send stack overflow/underflow to TRAP_VEC.
module pc_stack #(
  parameter int AW = 16,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter logic [AW-1:0] TRAP_VEC = 16'hFFF0
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     pcload,
  input  logic                     pcinc,
  input  logic                     pcbr,
  input  logic                     call,
  input  logic                     ret,
  input  logic [AW-1:0]            din,
  input  logic [AW-1:0]            offset,
  output logic [AW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);
  localparam int IW = $clog2(DEPTH);
`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [AW-1:0] stack [DEPTH];
  logic [AW-1:0] pc_nxt, pc_inc;
  logic [IW:0]   sp_nxt;
  logic [IW-1:0] top;
  logic          push, pop, fault;
  assign top    = sp[IW-1:0];
  assign full   = sp == (IW+1)'(DEPTH);
  assign empty  = sp == '0;
  assign pc_inc = dout + 1'b1;
  assign pop    = ret && !empty;
  assign push   = !ret && call && !full;
  assign fault  = ret ? empty : call && full;
  // ret outranks call, so a fault is either an empty pop or a full push
  always_comb begin
    pc_nxt = ret    ? (empty ? (TRAP ? TRAP_VEC : dout) : stack[top - 1'b1])
           : call   ? (full && TRAP ? TRAP_VEC : din)
           : pcload ? din
           : pcbr   ? dout + offset
           : pcinc  ? pc_inc
           : dout;
    sp_nxt = pop ? sp - 1'b1 : push ? sp + 1'b1 : sp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VEC;
      sp   <= '0;
      err  <= 1'b0;
    end else if (!stall) begin
      dout <= pc_nxt;
      sp   <= sp_nxt;
      err  <= err | fault;
      if (push) stack[top] <= pc_inc;
    end
  end
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: table-driven directed check of pc_stack, plus stall and no-combinational-path sequences.
module tb_pc_stack;
  localparam logic [6:0] R = 7'b1000000, S = 7'b0100000, RT = 7'b0010000, CL = 7'b0001000,
                         LD = 7'b0000100, BR = 7'b0000010, IN = 7'b0000001;
`ifdef PC_TRAP_EN
  localparam logic [15:0] OVF = 16'hFFF0, UNF = 16'hFFF0;
`else
  localparam logic [15:0] OVF = 16'h0A00, UNF = 16'h0001;
`endif
  logic clk = 1'b0;
  logic rst, stall, pcload, pcinc, pcbr, call, ret;
  logic [15:0] din, offset, dout;
  logic [2:0] sp;
  logic full, empty, err;
  int total = 0, passed = 0;
  typedef struct {
    logic [6:0]  cmd;
    logic [15:0] din;
    logic [15:0] off;
    logic [15:0] dout;
    logic [2:0]  sp;
    logic        err;
  } vec_t;
  vec_t vq[$];
  pc_stack dut (
    .clk(clk), .rst(rst), .stall(stall), .pcload(pcload), .pcinc(pcinc), .pcbr(pcbr),
    .call(call), .ret(ret), .din(din), .offset(offset), .dout(dout), .sp(sp),
    .full(full), .empty(empty), .err(err)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [6:0] c, logic [15:0] d, logic [15:0] o,
                              logic [15:0] e, logic [2:0] s, logic er);
    vec_t v;
    v.cmd = c; v.din = d; v.off = o; v.dout = e; v.sp = s; v.err = er;
    return v;
  endfunction
  task automatic drive(input logic [6:0] c, input logic [15:0] d, input logic [15:0] o);
    {rst, stall, ret, call, pcload, pcbr, pcinc} = c;
    din = d;
    offset = o;
  endtask
  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
  endtask
  task automatic chk_all(input int idx, input logic [15:0] e, input logic [2:0] s, input logic er);
    chk("dout", idx, dout, e);
    chk("sp", idx, {13'd0, sp}, {13'd0, s});
    chk("err", idx, {15'd0, err}, {15'd0, er});
    chk("full", idx, {15'd0, full}, {15'd0, s == 3'd4});
    chk("empty", idx, {15'd0, empty}, {15'd0, s == 3'd0});
  endtask
  initial begin
    drive(R, 16'h0, 16'h0);
    vq.push_back(mk(R,       16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(R,       16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(IN,      16'h0000, 16'h0000, 16'h0001, 3'd0, 1'b0));
    vq.push_back(mk(IN,      16'h0000, 16'h0000, 16'h0002, 3'd0, 1'b0));
    vq.push_back(mk(IN,      16'h0000, 16'h0000, 16'h0003, 3'd0, 1'b0));
    vq.push_back(mk(LD,      16'h0010, 16'h0000, 16'h0010, 3'd0, 1'b0));
    vq.push_back(mk(LD | IN, 16'h0100, 16'h0000, 16'h0100, 3'd0, 1'b0));
    vq.push_back(mk(BR,      16'h0000, 16'hFFFC, 16'h00FC, 3'd0, 1'b0));
    vq.push_back(mk(BR,      16'h0000, 16'h0004, 16'h0100, 3'd0, 1'b0));
    vq.push_back(mk(BR | IN, 16'h0000, 16'h0002, 16'h0102, 3'd0, 1'b0));
    vq.push_back(mk(LD,      16'h0005, 16'h0000, 16'h0005, 3'd0, 1'b0));
    vq.push_back(mk(CL | LD, 16'h0200, 16'h0000, 16'h0200, 3'd1, 1'b0));
    vq.push_back(mk(CL,      16'h0300, 16'h0000, 16'h0300, 3'd2, 1'b0));
    vq.push_back(mk(RT | CL, 16'h0700, 16'h0000, 16'h0201, 3'd1, 1'b0));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, 16'h0006, 3'd0, 1'b0));
    vq.push_back(mk(R,       16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(CL,      16'h0A00, 16'h0000, 16'h0A00, 3'd1, 1'b0));
    vq.push_back(mk(CL,      16'h0A00, 16'h0000, 16'h0A00, 3'd2, 1'b0));
    vq.push_back(mk(CL,      16'h0A00, 16'h0000, 16'h0A00, 3'd3, 1'b0));
    vq.push_back(mk(CL,      16'h0A00, 16'h0000, 16'h0A00, 3'd4, 1'b0));
    vq.push_back(mk(CL,      16'h0A00, 16'h0000, OVF,      3'd4, 1'b1));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, 16'h0A01, 3'd3, 1'b1));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, 16'h0A01, 3'd2, 1'b1));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, 16'h0A01, 3'd1, 1'b1));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, 16'h0001, 3'd0, 1'b1));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, UNF,      3'd0, 1'b1));
    vq.push_back(mk(CL,      16'h0400, 16'h0000, 16'h0400, 3'd1, 1'b1));
    vq.push_back(mk(S | CL,  16'h0300, 16'h0000, 16'h0400, 3'd1, 1'b1));
    vq.push_back(mk(S | RT,  16'h0000, 16'h0000, 16'h0400, 3'd1, 1'b1));
    vq.push_back(mk(R | CL,  16'h0300, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(R | S | RT, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(LD,      16'hFFFF, 16'h0000, 16'hFFFF, 3'd0, 1'b0));
    vq.push_back(mk(IN,      16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(LD,      16'hFFFF, 16'h0000, 16'hFFFF, 3'd0, 1'b0));
    vq.push_back(mk(CL,      16'h1000, 16'h0000, 16'h1000, 3'd1, 1'b0));
    vq.push_back(mk(RT,      16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0));
    vq.push_back(mk(LD,      16'h0002, 16'h0000, 16'h0002, 3'd0, 1'b0));
    vq.push_back(mk(BR,      16'h0000, 16'hFFFE, 16'h0000, 3'd0, 1'b0));
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].cmd, vq[i].din, vq[i].off);
      @(posedge clk);
      #1;
      chk_all(i, vq[i].dout, vq[i].sp, vq[i].err);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(S | IN, 16'h0, 16'h0);
      @(posedge clk);
      #1;
      chk("stall_hold", 100 + i, dout, 16'h0000);
    end
    @(negedge clk);
    drive(IN, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("stall_release", 103, dout, 16'h0001);
    @(negedge clk);
    drive(LD, 16'hABCD, 16'h0);
    #1;
    chk("no_comb_path", 104, dout, 16'h0001);
    @(posedge clk);
    #1;
    chk("load_after_edge", 105, dout, 16'hABCD);
    @(negedge clk);
    drive(7'd0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("idle_hold", 106, dout, 16'hABCD);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
